// File: rtl/sd_dma_mem_bridge.sv
// Presents a plain 32-bit slave to SD DMA and splits each word into two 16-bit accesses, high half first.
// Optional per-halfword ack timeout: define SD_DMA_BRIDGE_TIMEOUT_EN.
module sd_dma_mem_bridge #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_dma_request,
   input  logic        i_dma_write,
   output logic        o_dma_busy,
   output logic        o_dma_ack,
   input  logic [3:0]  i_dma_bank,
   input  logic [23:0] i_dma_address,
   input  logic [31:0] i_dma_data,
   output logic [31:0] o_dma_data,
   output logic        o_mem_request,
   output logic        o_mem_write,
   input  logic        i_mem_busy,
   input  logic        i_mem_ack,
   output logic [3:0]  o_mem_bank,
   output logic [23:0] o_mem_address,
   output logic [15:0] o_mem_data,
   input  logic [15:0] i_mem_data,
   output logic        o_timeout,
   input  logic        i_timeout_clear
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HI_REQ  = 3'd1,
      HI_WAIT = 3'd2,
      LO_REQ  = 3'd3,
      LO_WAIT = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t      state;
   logic [15:0] wdata_lo;

   // Word-aligned addressing: the two low byte-address bits carry no meaning here.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^i_dma_address[1:0];

`ifdef SD_DMA_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] wait_cnt;
   logic             wait_expired;
   // Counts WAIT cycles already spent without ack, so the T-th silent cycle expires.
   assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = i_timeout_clear ^ (TIMEOUT_CYCLES == 0);
   assign o_timeout = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= IDLE;
         o_dma_busy    <= 1'b0;
         o_dma_ack     <= 1'b0;
         o_dma_data    <= '0;
         o_mem_request <= 1'b0;
         o_mem_write   <= 1'b0;
         o_mem_bank    <= '0;
         o_mem_address <= '0;
         o_mem_data    <= '0;
`ifdef SD_DMA_BRIDGE_TIMEOUT_EN
         wait_cnt      <= '0;
         o_timeout     <= 1'b0;
`endif
      end else begin
         o_dma_ack <= 1'b0;
`ifdef SD_DMA_BRIDGE_TIMEOUT_EN
         // A timeout raised later in this cycle overrides the clear.
         if (i_timeout_clear)
            o_timeout <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (i_dma_request) begin
                  state         <= HI_REQ;
                  o_dma_busy    <= 1'b1;
                  o_mem_request <= 1'b1;
                  o_mem_write   <= i_dma_write;
                  o_mem_bank    <= i_dma_bank;
                  o_mem_address <= {i_dma_address[23:2], 2'b00};
                  o_mem_data    <= i_dma_data[31:16];
                  wdata_lo      <= i_dma_data[15:0];
               end
            end
            HI_REQ: begin
               if (!i_mem_busy) begin
                  state         <= HI_WAIT;
                  o_mem_request <= 1'b0;
`ifdef SD_DMA_BRIDGE_TIMEOUT_EN
                  wait_cnt      <= '0;
`endif
               end
            end
            HI_WAIT: begin
               if (i_mem_ack) begin
                  if (!o_mem_write)
                     o_dma_data[31:16] <= i_mem_data;
                  state         <= LO_REQ;
                  o_mem_request <= 1'b1;
                  o_mem_address <= o_mem_address + 24'd2;
                  o_mem_data    <= wdata_lo;
               end
`ifdef SD_DMA_BRIDGE_TIMEOUT_EN
               else if (wait_expired) begin
                  // Both halves are missing; the low phase is skipped entirely.
                  if (!o_mem_write)
                     o_dma_data <= 32'hFFFF_FFFF;
                  o_timeout <= 1'b1;
                  o_dma_ack <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            LO_REQ: begin
               if (!i_mem_busy) begin
                  state         <= LO_WAIT;
                  o_mem_request <= 1'b0;
`ifdef SD_DMA_BRIDGE_TIMEOUT_EN
                  wait_cnt      <= '0;
`endif
               end
            end
            LO_WAIT: begin
               if (i_mem_ack) begin
                  if (!o_mem_write)
                     o_dma_data[15:0] <= i_mem_data;
                  o_dma_ack <= 1'b1;
                  state     <= DONE;
               end
`ifdef SD_DMA_BRIDGE_TIMEOUT_EN
               else if (wait_expired) begin
                  if (!o_mem_write)
                     o_dma_data[15:0] <= 16'hFFFF;
                  o_timeout <= 1'b1;
                  o_dma_ack <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               state      <= IDLE;
               o_dma_busy <= 1'b0;
            end
            default: begin
               state         <= IDLE;
               o_dma_busy    <= 1'b0;
               o_mem_request <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_dma_mem_bridge.sv
// Bench for sd_dma_mem_bridge: directed and randomized DMA words against a transaction-level model.
`timescale 1ns/1ps
module tb_sd_dma_mem_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        dma_req, dma_write, dma_busy, dma_ack;
   logic [3:0]  dma_bank;
   logic [23:0] dma_addr;
   logic [31:0] dma_wdata, dma_rdata;
   logic        mem_req, mem_write, mem_busy, mem_ack;
   logic [3:0]  mem_bank;
   logic [23:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        timeout, timeout_clear;

   int checks = 0;
   int errors = 0;
   int ack_cnt = 0;

   always #5 clk = ~clk;

   sd_dma_mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_dma_request(dma_req), .i_dma_write(dma_write), .o_dma_busy(dma_busy), .o_dma_ack(dma_ack),
      .i_dma_bank(dma_bank), .i_dma_address(dma_addr), .i_dma_data(dma_wdata), .o_dma_data(dma_rdata),
      .o_mem_request(mem_req), .o_mem_write(mem_write), .i_mem_busy(mem_busy), .i_mem_ack(mem_ack),
      .o_mem_bank(mem_bank), .o_mem_address(mem_addr), .o_mem_data(mem_wdata), .i_mem_data(mem_rdata),
      .o_timeout(timeout), .i_timeout_clear(timeout_clear)
   );

   // Memory environment: busy stretch per request, ack a fixed number of cycles after accept.
   typedef struct {
      logic        w;
      logic [3:0]  b;
      logic [23:0] a;
      logic [15:0] d;
      int          req_len;
      bit          stable;
   } acc_t;

   acc_t        log_q[$];
   logic [15:0] phys[logic [27:0]];
   logic [15:0] ref_mem[logic [27:0]];
   int          busy_cycles = 0;
   int          ack_delay = 1;
   bit          ack_en = 1'b1;
   bit          spur = 1'b0;
   logic [31:0] last_rd = '0;

   function automatic logic [15:0] init_val(input logic [27:0] k);
      return k[15:0] ^ {k[27:24], 12'h5A3};
   endfunction

   function automatic logic [15:0] ref_rd(input logic [27:0] k);
      return ref_mem.exists(k) ? ref_mem[k] : init_val(k);
   endfunction

   always @(posedge clk) if (dma_ack) ack_cnt <= ack_cnt + 1;

   initial begin : responder
      int bl, cnt, rlen;
      bit in_req, stab, acc;
      logic [44:0] snap;
      logic [15:0] pend;
      logic [27:0] key;
      acc_t e;
      bl = 0; cnt = 0; rlen = 0; in_req = 0; stab = 1; snap = '0; pend = '0;
      mem_busy = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk);
         acc = mem_req && !mem_busy && !rst;
         if (acc) begin
            key = {mem_bank, mem_addr};
            e.w = mem_write; e.b = mem_bank; e.a = mem_addr; e.d = mem_wdata;
            e.req_len = rlen; e.stable = stab;
            log_q.push_back(e);
            if (mem_write) phys[key] = mem_wdata;
            pend = phys.exists(key) ? phys[key] : init_val(key);
         end
         #1;
         mem_ack = 1'b0;
         mem_rdata = 16'($urandom);
         if (rst) cnt = 0;
         else if (acc) cnt = ack_delay;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && ack_en) begin
               mem_ack = 1'b1;
               mem_rdata = pend;
            end
         end else if (spur && ack_en) begin
            mem_ack = 1'($urandom);
         end
         if (mem_req && !rst) begin
            if (!in_req) begin
               in_req = 1; bl = busy_cycles; rlen = 0; stab = 1;
               snap = {mem_write, mem_bank, mem_addr, mem_wdata};
            end else if (snap !== {mem_write, mem_bank, mem_addr, mem_wdata}) begin
               stab = 0;
            end
            rlen++;
            mem_busy = (bl > 0);
            if (bl > 0) bl--;
         end else begin
            in_req = 0;
            mem_busy = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(dma_busy), 0);
      check({tag, "_ack"}, 32'(dma_ack), 0);
      check({tag, "_rdata"}, dma_rdata, 0);
      check({tag, "_mreq"}, 32'(mem_req), 0);
      check({tag, "_mwrite"}, 32'(mem_write), 0);
      check({tag, "_mbank"}, 32'(mem_bank), 0);
      check({tag, "_maddr"}, 32'(mem_addr), 0);
      check({tag, "_mdata"}, 32'(mem_wdata), 0);
      check({tag, "_timeout"}, 32'(timeout), 0);
   endtask

   // One DMA word with the memory stretched by bsy busy cycles and acking dly cycles after accept.
   task automatic xfer(input bit w, input logic [3:0] b, input logic [23:0] a, input logic [31:0] d,
                       input int bsy, input int dly);
      int n, ack0;
      bit got;
      logic [23:0] al;
      busy_cycles = bsy; ack_delay = dly;
      @(posedge clk); #2;
      log_q.delete();
      ack0 = ack_cnt;
      dma_req = 1'b1; dma_write = w; dma_bank = b; dma_addr = a; dma_wdata = d;
      check("idle_not_busy", 32'(dma_busy), 0);
      n = 0; got = 0;
      while (!got && n < 300) begin
         @(posedge clk); #2; n++;
         if (n == 1) begin
            dma_req = 1'b0; dma_write = !w; dma_bank = ~b; dma_addr = ~a; dma_wdata = ~d;
            check("busy_after_accept", 32'(dma_busy), 1);
         end
         got = dma_ack;
      end
      check("ack_seen", 32'(got), 1);
      check("latency", n, 1 + 2 * (bsy + 1 + dly));
      al = a & 24'hFFFFFC;
      check("mem_acc_count", log_q.size(), 2);
      for (int i = 0; i < log_q.size() && i < 2; i++) begin
         check("acc_write", 32'(log_q[i].w), 32'(w));
         check("acc_bank", 32'(log_q[i].b), 32'(b));
         check("acc_addr", 32'(log_q[i].a), 32'(al + 24'(2 * i)));
         check("acc_req_len", log_q[i].req_len, bsy + 1);
         check("acc_stable", 32'(log_q[i].stable), 1);
         if (w) check("acc_wdata", 32'(log_q[i].d), (i == 0) ? 32'(d[31:16]) : 32'(d[15:0]));
      end
      if (w) begin
         ref_mem[{b, al}] = d[31:16];
         ref_mem[{b, al + 24'd2}] = d[15:0];
      end else begin
         last_rd = {ref_rd({b, al}), ref_rd({b, al + 24'd2})};
      end
      check("dma_data", dma_rdata, last_rd);
      @(posedge clk); #2;
      check("ack_one_cycle", 32'(dma_ack), 0);
      check("idle_after_done", 32'(dma_busy), 0);
      check("ack_count", ack_cnt - ack0, 1);
   endtask

   initial begin : main
      int n, k, ack0;
      int t[3];
      logic [31:0] wd[3];
      rst = 1'b1; dma_req = 1'b0; dma_write = 1'b0; dma_bank = '0; dma_addr = '0; dma_wdata = '0;
      timeout_clear = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_all_zero("reset");
      rst = 1'b0;

      // Read from bank 2 with preloaded halfwords, unaligned address.
      phys[{4'd2, 24'h001000}] = 16'h1234; ref_mem[{4'd2, 24'h001000}] = 16'h1234;
      phys[{4'd2, 24'h001002}] = 16'hABCD; ref_mem[{4'd2, 24'h001002}] = 16'hABCD;
      xfer(1'b0, 4'd2, 24'h001003, 32'h0, 0, 1);
      check("tc1_data", dma_rdata, 32'h1234ABCD);

      // Write at top of address space with a busy memory.
      xfer(1'b1, 4'd7, 24'hFFFFFC, 32'hDEADBEEF, 3, 1);
      check("tc2_hi", 32'(phys[{4'd7, 24'hFFFFFC}]), 32'h0000DEAD);
      check("tc2_lo", 32'(phys[{4'd7, 24'hFFFFFE}]), 32'h0000BEEF);

      // Spurious acks while idle, then during a transfer outside the WAIT states.
      spur = 1'b1;
      ack0 = ack_cnt;
      repeat (6) @(posedge clk);
      #2;
      check("spur_idle_busy", 32'(dma_busy), 0);
      check("spur_idle_ack", ack_cnt - ack0, 0);
      xfer(1'b0, 4'd7, 24'hFFFFFC, 32'h0, 2, 2);
      spur = 1'b0;

      // Reset while waiting for the low halfword ack.
      busy_cycles = 0; ack_delay = 4;
      @(posedge clk); #2;
      log_q.delete();
      ack0 = ack_cnt;
      dma_req = 1'b1; dma_write = 1'b0; dma_bank = 4'd3; dma_addr = 24'h000040;
      n = 0;
      while (log_q.size() < 2 && n < 50) begin
         @(posedge clk); #2; n++;
         if (n == 1) dma_req = 1'b0;
      end
      check("rst_reached_lo", log_q.size(), 2);
      rst = 1'b1;
      @(posedge clk); #2;
      check_all_zero("midrst");
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check("midrst_no_ack", ack_cnt - ack0, 0);
      last_rd = '0;
      xfer(1'b0, 4'd3, 24'h000040, 32'h0, 0, 1);

      // Back-to-back writes with the request held high.
      busy_cycles = 0; ack_delay = 1;
      wd[0] = 32'h11112222; wd[1] = 32'h33334444; wd[2] = 32'h55556666;
      @(posedge clk); #2;
      log_q.delete();
      ack0 = ack_cnt;
      dma_req = 1'b1; dma_write = 1'b1; dma_bank = 4'd5; dma_addr = 24'h000200; dma_wdata = wd[0];
      k = 0; n = 0; t[0] = 0; t[1] = 0; t[2] = 0;
      while (k < 3 && n < 100) begin
         @(posedge clk); #2; n++;
         if (dma_ack) begin
            t[k] = n; k++;
            if (k < 3) begin
               dma_addr = 24'h000200 + 24'(4 * k); dma_wdata = wd[k];
            end else begin
               dma_req = 1'b0;
            end
         end
      end
      check("b2b_acks", k, 3);
      for (int i = 0; i < 3; i++) check("b2b_ack_time", t[i], 5 + 6 * i);
      check("b2b_acc_count", log_q.size(), 6);
      for (int i = 0; i < log_q.size() && i < 6; i++) begin
         check("b2b_addr", 32'(log_q[i].a), 32'(24'h000200 + 24'(2 * i)));
         check("b2b_data", 32'(log_q[i].d), (i % 2 == 0) ? 32'(wd[i / 2][31:16]) : 32'(wd[i / 2][15:0]));
      end
      for (int i = 0; i < 3; i++) begin
         ref_mem[{4'd5, 24'h000200 + 24'(4 * i)}] = wd[i][31:16];
         ref_mem[{4'd5, 24'h000202 + 24'(4 * i)}] = wd[i][15:0];
      end
      repeat (3) @(posedge clk);
      #2;
      check("b2b_total_acks", ack_cnt - ack0, 3);
      check("b2b_idle", 32'(dma_busy), 0);

      // Randomized words over a small overlapping address window.
      for (int i = 0; i < 12; i++) begin
         spur = 1'($urandom);
         xfer(1'($urandom), 4'($urandom_range(0, 3)),
              24'h000100 + 24'($urandom_range(0, 7)) * 24'd4 + 24'($urandom_range(0, 3)),
              $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
      end
      spur = 1'b0;
      // Readback of one written location confirms the write data landed where modelled.
      xfer(1'b0, 4'd5, 24'h000204, 32'h0, 0, 1);
      check("b2b_readback", dma_rdata, 32'h33334444);

`ifdef SD_DMA_BRIDGE_TIMEOUT_EN
      // Read against a memory that never acks.
      ack_en = 1'b0; busy_cycles = 0; ack_delay = 1;
      @(posedge clk); #2;
      log_q.delete();
      dma_req = 1'b1; dma_write = 1'b0; dma_bank = 4'd1; dma_addr = 24'h000080;
      n = 0;
      while (!dma_ack && n < 100) begin
         @(posedge clk); #2; n++;
         if (n == 1) dma_req = 1'b0;
      end
      check("to_ack_time", n, 10);
      check("to_data", dma_rdata, 32'hFFFFFFFF);
      check("to_flag", 32'(timeout), 1);
      check("to_acc_count", log_q.size(), 1);
      repeat (3) @(posedge clk);
      #2;
      check("to_sticky", 32'(timeout), 1);
      timeout_clear = 1'b1;
      @(posedge clk); #2;
      timeout_clear = 1'b0;
      check("to_cleared", 32'(timeout), 0);
      ack_en = 1'b1;
      last_rd = 32'hFFFFFFFF;
      xfer(1'b0, 4'd1, 24'h000080, 32'h0, 1, 1);
`else
      check("timeout_tied_low", 32'(timeout), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
